uart_rx_fifo: RTL and testbench

Receive-side byte buffer directly downstream of the UART receiver. Captures every byte the receiver completes (one `rx_done_tick` strobe plus `rx_data`) into a circular FIFO and presents it to the CPU bus interface as a first-word-fall-through queue. Provides status flags, a sticky overrun flag and an optional interrupt request.

---
 rtl/uart_rx_fifo.sv | 126 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive byte FIFO behind the UART receiver.
// Define UART_RX_FIFO_IRQ_EN to build the threshold/overrun/idle-timeout interrupt.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned THRESHOLD  = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [7:0]            rx_data,
  input  logic                  rd_en,
  input  logic                  clr_overrun,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overrun,
  output logic                  irq
);
  localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH_LOG2 out of range");
  end
  if (THRESHOLD < 1 || THRESHOLD > DEPTH) begin : g_bad_threshold
    $error("uart_rx_fifo: THRESHOLD out of range");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("uart_rx_fifo: TIMEOUT out of range");
  end

  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic                  push, pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == DEPTH_LVL);
  assign level   = level_q;
  assign overrun = overrun_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push = rx_done_tick && (!full || rd_en);
  assign pop  = rd_en && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    overrun_d = overrun_q;
    if (rx_done_tick && full && !rd_en) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        irq_q, irq_d;
  logic        timeout_hit;

  always_comb begin
    timeout_hit = (idle_cnt_q == 16'(TIMEOUT)) && (level_q != '0);
    idle_cnt_d  = idle_cnt_q;
    if (push || pop || (level_d == '0)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != 16'(TIMEOUT)) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
    irq_d = (level_d >= (DEPTH_LOG2 + 1)'(THRESHOLD)) || overrun_d || timeout_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus directed literal checks.
// Interrupt expectations follow UART_RX_FIFO_IRQ_EN when it is defined for the build.
module tb_uart_rx_fifo;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int TH    = 8;
  localparam int TO    = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rd_en;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [DL2:0] level;
  logic       overrun;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DEPTH_LOG2(DL2), .THRESHOLD(TH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rd_en(rd_en), .clr_overrun(clr_overrun), .rd_data(rd_data), .empty(empty),
    .full(full), .level(level), .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue, a sticky flag, and the edge index of the last activity.
  logic [7:0] mq[$];
  bit m_ovr;
  bit m_irq;
  int ecount;
  int last_event;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ovr      = 0;
      m_irq      = 0;
      ecount     = 0;
      last_event = 0;
    end else begin
      int  lvl_before, idle_before;
      bit  was_full, do_push, do_pop;
      lvl_before  = mq.size();
      was_full    = (lvl_before == DEPTH);
      idle_before = (ecount - last_event > TO) ? TO : ecount - last_event;
      do_push = rx_done_tick && (!was_full || rd_en);
      do_pop  = rd_en && (lvl_before != 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(rx_data);
      if (rx_done_tick && was_full && !rd_en) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      ecount++;
      if (do_push || do_pop || mq.size() == 0) last_event = ecount;
`ifdef UART_RX_FIFO_IRQ_EN
      m_irq = (mq.size() >= TH) || m_ovr || (idle_before == TO && lvl_before != 0);
`else
      m_irq = 0;
`endif
    end
  end

  always @(negedge clk) begin
    check("cyc_rd_data", rd_data, (mq.size() == 0) ? 0 : int'(mq[0]));
    check("cyc_level",   level,   mq.size());
    check("cyc_empty",   empty,   mq.size() == 0);
    check("cyc_full",    full,    mq.size() == DEPTH);
    check("cyc_overrun", overrun, m_ovr);
    check("cyc_irq",     irq,     m_irq);
  end

  task automatic cyc(input logic rx, input logic [7:0] d, input logic rd, input logic clr);
    rx_done_tick = rx;
    rx_data      = d;
    rd_en        = rd;
    clr_overrun  = clr;
    @(posedge clk);
    #2;
    rx_done_tick = 1'b0;
    rd_en        = 1'b0;
    clr_overrun  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && !empty; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", empty, 1);
  endtask

  initial begin
    int nxt;
    reset = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00; rd_en = 1'b0; clr_overrun = 1'b0;
    #12;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_irq", irq, 0);
    reset = 1'b1;
    @(posedge clk); #2;

    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    check("push1_empty", empty, 0);
    check("push1_level", level, 1);
    check("push1_rd_data", rd_data, 8'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop1_empty", empty, 1);
    check("pop1_rd_data", rd_data, 0);

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", full, 1);
    check("fill_level", level, 16);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_overrun", overrun, 1);
    check("ovf_level", level, 16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_overrun", overrun, 0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check("fullrw_level", level, 16);
    check("fullrw_overrun", overrun, 0);
    check("fullrw_head", rd_data, 8'h01);
    for (int i = 1; i < 16; i++) begin
      check("fullrw_order", rd_data, i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("fullrw_last", rd_data, 8'h77);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("fullrw_empty", empty, 1);

    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    check("emptyrw_level", level, 1);
    check("emptyrw_rd_data", rd_data, 8'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    check("ovf2_overrun", overrun, 1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    check("setclr_overrun", overrun, 1);
    check("setclr_head", rd_data, 8'h80);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr2_overrun", overrun, 0);
    drain();

    nxt = 0;
    for (int i = 0; i < 40; i++) begin
      bit rd;
      rd = (mq.size() >= 4);
      if (rd) begin
        check("wrap_order", rd_data, nxt);
        nxt++;
      end
      cyc(1'b1, 8'(i), rd, 1'b0);
      check("wrap_level_max", int'(level) <= 5, 1);
    end
    for (int i = 0; i < 10 && !empty; i++) begin
      check("wrap_order", rd_data, nxt);
      nxt++;
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("wrap_count", nxt, 40);

`ifdef UART_RX_FIFO_IRQ_EN
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      check("irq_idle_low", irq, 0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("irq_timeout_high", irq, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("irq_popped_low", irq, 0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("irq_below_th", irq, 0);
    cyc(1'b1, 8'h07, 1'b0, 1'b0);
    check("irq_at_th", irq, 1);
    drain();
`else
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("irq_disabled", irq, 0);
    drain();
`endif

    for (int c = 0; c < 3000; c++) begin
      int prx, prd;
      if (c < 1000)      begin prx = 2;  prd = 3;  end
      else if (c < 1500) begin prx = 20; prd = 30; end
      else               begin prx = 3;  prd = 2;  end
      if (c == 1200) begin
        reset = 1'b0;
        #1;
        check("async_rst_empty", empty, 1);
        check("async_rst_level", level, 0);
        @(negedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
      end
      cyc(($urandom % prx) == 0, 8'($urandom), ($urandom % prd) == 0, ($urandom % 16) == 0);
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
